kernel_alarm_capture: RTL and testbench
=======================================

# kernel_alarm_capture

Parametrised successor to the kernel's single-bank alarm input port: an Avalon-MM slave that synchronises `WIDTH` external alarm lines, optionally debounces them, and detects per-channel rising and/or falling edges. Captured events are latched in a write-1-to-clear register, counted, and combined with a mask into a registered interrupt to the Nios kernel. It sits between the board alarm inputs and the kernel's Avalon interconnect.

## Interface
- `WIDTH`, 8: number of alarm channels, 1..32.
- `SYNC_STAGES`, 2: synchroniser flops per channel, minimum 2.
- `DEB_W`, 16: debounce counter and `DEBOUNCE_LEN` width, 1..32.
- `clk` in 1: single clock for all logic.
- `reset` in 1: **synchronous, active-high** reset.
- `address` in 3: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in `WIDTH`: asynchronous alarm inputs.
- `readdata` out 32: registered read data, reset 0.
- `irq` out 1: registered interrupt, reset 0.

## Operation
- Write strobe: `chipselect && !write_n`. Reads have no side effects.
- Register map; unused upper bits read 0:
  - 0 `DATA` (RO): filtered levels.
  - 1 `RISE_EN` (RW): per-channel rising-edge enable.
  - 2 `IRQ_MASK` (RW).
  - 3 `EDGE_CAPTURE` (W1C).
  - 4 `FALL_EN` (RW).
  - 5 `DEBOUNCE_LEN` (RW, `DEB_W` bits).
  - 6 `EVENT_COUNT` (RO, 16-bit; any write clears it).
  - 7 `RAW` (RO): synchroniser output, before the filter.
- Pipeline per channel: synchroniser → filter → `filt_d` (one-cycle delay of the filtered level).
  - `rise = filt & ~filt_d`
  - `fall = ~filt & filt_d`
  - `ev = (rise & RISE_EN) | (fall & FALL_EN)`
- `EDGE_CAPTURE[i]` sets when `ev[i]`. It clears on a write to address 3 with `writedata[i]=1`. **Set wins** over a simultaneous clear.
- `EVENT_COUNT` increments by 1 in any cycle where `|ev` is true, regardless of channel count. It saturates at 0xFFFF. A clear write in the same cycle as an event loads 1.
- `irq <= |(EDGE_CAPTURE & IRQ_MASK)`, computed on the register's current value.
- Reset: all registers, synchroniser flops, filter state, `filt_d`, counters, `readdata` and `irq` go to 0.
  - A line held high through reset yields one `rise` after sync. It is not captured, because `RISE_EN` is 0 after reset.
  - Reset mid-debounce discards the partial count.

## Timing
- `readdata` is valid on the cycle after the read address is presented; 1-cycle read latency, no wait states. The mux is sampled every cycle.
- Register writes take effect on the next edge. A read in the following cycle returns the new value.
- `RAW` reflects `in_port` `SYNC_STAGES` cycles after a change.
- With debounce and length L, a change on `RAW` must hold for L+1 consecutive cycles before `filt` follows.
  - A mismatch shorter than that is discarded and its counter reset to 0.
  - L=0 updates `filt` on the first mismatching cycle.
- `EDGE_CAPTURE` sets 1 cycle after `filt` changes; `irq` asserts 1 cycle later.
- Total input-to-irq latency: `SYNC_STAGES + L + 3` cycles.
- Writing `DEBOUNCE_LEN` mid-count: the new L applies from the next cycle, compared against the running count (`>=`).

## Configuration
- `ALARM_DEBOUNCE_EN` defined: filter counters and the `DEBOUNCE_LEN` register are implemented.
- Undefined:
  - `filt` equals `RAW` (combinational pass-through).
  - Address 5 reads 0 and writes are ignored.
  - Input-to-irq latency is `SYNC_STAGES + 2` cycles.

## Structure
- Package `kernel_alarm_pkg` holds:
  - Register address constants (`ALARM_ADDR_DATA` … `ALARM_ADDR_RAW`).
  - `EVENT_COUNT` width (16) and its saturation constant.
- One sub-module, `alarm_debounce`: a single-channel filter (counter plus filtered-level flop, `DEB_W` parameter). It is instantiated `WIDTH` times in a generate loop, only under `ALARM_DEBOUNCE_EN`.

## Test plan
- Reset behaviour: after reset, read addresses 0–7 → all 0 (address 0 reads 0 only with `in_port` low); `irq` = 0.
- Rising capture: `WIDTH`=8, `SYNC_STAGES`=2, L=0, `RISE_EN`=0x01, `IRQ_MASK`=0x01, `in_port[0]` 0→1 → `irq` high exactly 5 cycles later. `EDGE_CAPTURE`=0x01, `EVENT_COUNT`=1.
- Falling and W1C:
  - `FALL_EN`=0x80, drop `in_port[7]` → `EDGE_CAPTURE`=0x80.
  - Write 0x80 to address 3 → reads 0x00 and `irq` deasserts the cycle after the clear.
  - Simultaneous new edge and clear → bit stays 1.
- Debounce (macro on), L=4: 4-cycle glitch on `in_port[2]` → no `DATA` change, no capture. A 5-cycle pulse → `DATA[2]` rises; a later 6-cycle low → `DATA[2]` falls.
- Counter saturation:
  - Force 0x10000 events → `EVENT_COUNT`=0xFFFF.
  - Write address 6 → 0.
  - Clear coincident with an event → 1.
- Macro off: L written as 7 → address 5 reads 0; rising edge → `irq` at `SYNC_STAGES`+2 = 4 cycles.

Source files
------------

// File: rtl/kernel_alarm_pkg.sv
// kernel_alarm_pkg: register map and event counter constants for kernel_alarm_capture
package kernel_alarm_pkg;
    localparam logic [2:0] ALARM_ADDR_DATA         = 3'd0;
    localparam logic [2:0] ALARM_ADDR_RISE_EN      = 3'd1;
    localparam logic [2:0] ALARM_ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ALARM_ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ALARM_ADDR_FALL_EN      = 3'd4;
    localparam logic [2:0] ALARM_ADDR_DEBOUNCE_LEN = 3'd5;
    localparam logic [2:0] ALARM_ADDR_EVENT_COUNT  = 3'd6;
    localparam logic [2:0] ALARM_ADDR_RAW          = 3'd7;
    localparam int ALARM_CNT_W = 16;
    localparam logic [ALARM_CNT_W-1:0] ALARM_CNT_MAX = '1;
endpackage

// File: rtl/alarm_debounce.sv
// alarm_debounce: single-channel filter, follows raw after len+1 consecutive mismatching cycles
module alarm_debounce #(
    parameter int DEB_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DEB_W-1:0] len,
    input  logic             raw,
    output logic             filt
);
    logic [DEB_W-1:0] cnt;
    // count mismatching cycles; any agreement discards the partial count
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (raw == filt) begin
            cnt <= '0;
        end else if (cnt >= len) begin
            cnt  <= '0;
            filt <= raw;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/kernel_alarm_capture.sv
// kernel_alarm_capture: Avalon-MM alarm input port with edge capture and irq; ALARM_DEBOUNCE_EN adds per-channel debounce
module kernel_alarm_capture
    import kernel_alarm_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] raw, filt, filt_d, rise, fall, ev;
    logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edge_cap;
    logic [DEB_W-1:0] deb_len;
    logic [ALARM_CNT_W-1:0] event_count;
    logic [31:0] rd_mux;
    logic wr, unused_wd;

    assign wr        = chipselect && !write_n;
    assign unused_wd = ^writedata;
    assign raw       = sync_q[SYNC_STAGES-1];
    assign rise      = filt & ~filt_d;
    assign fall      = ~filt & filt_d;
    assign ev        = (rise & rise_en) | (fall & fall_en);

    // synchroniser chain for the asynchronous alarm lines
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef ALARM_DEBOUNCE_EN
    // debounce length register
    always_ff @(posedge clk) begin
        if (reset) deb_len <= '0;
        else if (wr && address == ALARM_ADDR_DEBOUNCE_LEN) deb_len <= writedata[DEB_W-1:0];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        alarm_debounce #(.DEB_W(DEB_W)) u_deb (
            .clk   (clk),
            .reset (reset),
            .len   (deb_len),
            .raw   (raw[i]),
            .filt  (filt[i])
        );
    end
`else
    assign deb_len = '0;
    assign filt    = raw;
`endif

    // control registers, edge capture, event counter, irq and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en     <= '0;
            fall_en     <= '0;
            irq_mask    <= '0;
            edge_cap    <= '0;
            filt_d      <= '0;
            event_count <= '0;
            irq         <= 1'b0;
            readdata    <= '0;
        end else begin
            if (wr && address == ALARM_ADDR_RISE_EN) rise_en <= writedata[WIDTH-1:0];
            if (wr && address == ALARM_ADDR_FALL_EN) fall_en <= writedata[WIDTH-1:0];
            if (wr && address == ALARM_ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
            edge_cap    <= (edge_cap & ~((wr && address == ALARM_ADDR_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0)) | ev;
            event_count <= (wr && address == ALARM_ADDR_EVENT_COUNT) ? {{(ALARM_CNT_W-1){1'b0}}, |ev} :
                           (|ev && event_count != ALARM_CNT_MAX) ? event_count + 1'b1 : event_count;
            filt_d      <= filt;
            irq         <= |(edge_cap & irq_mask);
            readdata    <= rd_mux;
        end
    end

    // read mux, zero-extended to the bus width
    always_comb begin
        rd_mux = '0;
        case (address)
            ALARM_ADDR_DATA:         rd_mux = 32'(filt);
            ALARM_ADDR_RISE_EN:      rd_mux = 32'(rise_en);
            ALARM_ADDR_IRQ_MASK:     rd_mux = 32'(irq_mask);
            ALARM_ADDR_EDGE_CAPTURE: rd_mux = 32'(edge_cap);
            ALARM_ADDR_FALL_EN:      rd_mux = 32'(fall_en);
            ALARM_ADDR_DEBOUNCE_LEN: rd_mux = 32'(deb_len);
            ALARM_ADDR_EVENT_COUNT:  rd_mux = 32'(event_count);
            ALARM_ADDR_RAW:          rd_mux = 32'(raw);
            default: ;
        endcase
    end
endmodule

// File: tb/tb_kernel_alarm_capture.sv
// tb_kernel_alarm_capture: directed self-checking bench for kernel_alarm_capture (WIDTH=8, SYNC_STAGES=2)
module tb_kernel_alarm_capture;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;
    logic [31:0] d;
    int n_vec = 0;
    int n_err = 0;

`ifdef ALARM_DEBOUNCE_EN
    localparam int LAT = 5, PRE = 3;
    localparam logic [31:0] L_RB = 32'd7;
`else
    localparam int LAT = 4, PRE = 2;
    localparam logic [31:0] L_RB = 32'd0;
`endif

    kernel_alarm_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEB_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        address = a;
        writedata = v;
        chipselect = 1'b1;
        write_n = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a;
        tick();
        v = readdata;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        address = '0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
        in_port = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_irq", 32'(irq), 0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            check($sformatf("reset_a%0d", a), d, 0);
        end
        wr(5, 7);
        rd(5, d);
        check("deb_len_rb", d, L_RB);
        wr(5, 0);

        wr(1, 32'h01);
        wr(2, 32'h01);
        in_port[0] = 1'b1;
        for (int n = 1; n <= LAT; n++) begin
            tick();
            if (n == LAT - 1) check("irq_early", 32'(irq), 0);
            if (n == LAT) check("irq_on_time", 32'(irq), 1);
        end
        rd(3, d); check("rise_cap", d, 32'h01);
        rd(6, d); check("rise_count", d, 32'd1);
        rd(0, d); check("rise_data", d, 32'h01);
        rd(7, d); check("rise_raw", d, 32'h01);

        wr(3, 32'h01);
        wr(2, 32'h81);
        wr(4, 32'h80);
        in_port[7] = 1'b1;
        repeat (10) tick();
        in_port[7] = 1'b0;
        repeat (10) tick();
        rd(3, d); check("fall_cap", d, 32'h80);
        check("fall_irq", 32'(irq), 1);
        wr(3, 32'h80);
        check("irq_after_clr_edge", 32'(irq), 1);
        tick();
        check("irq_deassert", 32'(irq), 0);
        rd(3, d); check("w1c_cap", d, 32'h00);

        in_port[7] = 1'b1;
        repeat (10) tick();
        in_port[7] = 1'b0;
        repeat (PRE) tick();
        wr(3, 32'h80);
        rd(3, d); check("set_wins", d, 32'h80);
        rd(6, d); check("count3", d, 32'd3);

        wr(1, 32'h03);
        wr(4, 32'h82);
        for (int i = 0; i < 32'h10010; i++) begin
            in_port[1] = ~in_port[1];
            tick();
        end
        repeat (10) tick();
        wr(1, 32'h01);
        wr(4, 32'h80);
        rd(6, d); check("count_sat", d, 32'hFFFF);
        wr(3, 32'h02);
        in_port[7] = 1'b1;
        repeat (10) tick();
        in_port[7] = 1'b0;
        repeat (PRE) tick();
        wr(6, 0);
        rd(6, d); check("count_clr_ev", d, 32'd1);
        wr(6, 0);
        rd(6, d); check("count_clr", d, 32'd0);

`ifdef ALARM_DEBOUNCE_EN
        wr(3, 32'hFF);
        wr(5, 4);
        wr(1, 32'h05);
        wr(4, 32'h84);
        in_port[2] = 1'b1;
        repeat (4) tick();
        in_port[2] = 1'b0;
        repeat (12) tick();
        rd(0, d); check("glitch_data", d, 32'h01);
        rd(3, d); check("glitch_cap", d, 32'h00);
        in_port[2] = 1'b1;
        repeat (5) tick();
        in_port[2] = 1'b0;
        repeat (12) tick();
        rd(3, d); check("pulse5_cap", d, 32'h04);
        wr(3, 32'hFF);
        in_port[2] = 1'b1;
        repeat (12) tick();
        rd(0, d); check("hold_high", d, 32'h05);
        wr(3, 32'hFF);
        in_port[2] = 1'b0;
        repeat (4) tick();
        in_port[2] = 1'b1;
        repeat (12) tick();
        rd(0, d); check("low_glitch_data", d, 32'h05);
        rd(3, d); check("low_glitch_cap", d, 32'h00);
        in_port[2] = 1'b0;
        repeat (12) tick();
        rd(0, d); check("fall_data", d, 32'h01);
        rd(3, d); check("fall_cap_deb", d, 32'h04);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
